pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
//
// PURPOSE
//   Consumer end of the PLL lock interface. Runs on the PLL output clock (the
//   20 MHz pixel clock). Qualifies the PLL 'locked' flag and only then releases
//   a clean, synchronous reset to the VGA text-mode core.
//   Any loss of lock re-asserts that reset immediately. Lock-loss events are
//   counted for debug.
//
// PARAMETERS
//   LOCK_STABLE_CYCLES  1024  consecutive cycles synced lock must stay high before HOLD (>=1)
//   HOLD_CYCLES         256   cycles core reset stays asserted after lock qualifies (>=1)
//   LOSS_COUNT_WIDTH    8     width of saturating lock-loss counter (>=1)
//
// PORTS
//   clock_in         input   1   PLL output clock; all logic on rising edge
//   reset            input   1   synchronous, active-high; forces WAIT_LOCK
//   locked           input   1   PLL lock flag, asynchronous to clock_in
//   reset_out        output  1   active-high reset to the VGA core; 1 in every state except RUN
//   ready            output  1   1 only in RUN (equals ~reset_out)
//   lock_loss_count  output  LOSS_COUNT_WIDTH  RUN->WAIT_LOCK transitions, saturating
//
// BEHAVIOUR
//   Lock synchroniser
//   - 'locked' passes through a 2-flop synchroniser: sync1 <= locked, sync2 <= sync1.
//   - locked_s = sync2. Nothing else samples 'locked'.
//
//   State machine: one-hot {WAIT_LOCK, STABLE, HOLD, RUN}; one shared counter cnt
//   - WAIT_LOCK: cnt <= 0. If locked_s, go to STABLE.
//   - STABLE: if !locked_s, go to WAIT_LOCK (cnt <= 0).
//       Else if cnt == LOCK_STABLE_CYCLES-1, go to HOLD (cnt <= 0).
//       Else cnt++.
//   - HOLD: if !locked_s, go to WAIT_LOCK.
//       Else if cnt == HOLD_CYCLES-1, go to RUN.
//       Else cnt++.
//   - RUN: if !locked_s, go to WAIT_LOCK and increment lock_loss_count (saturating).
//
//   Outputs
//   - reset_out = ~state_RUN and ready = state_RUN, decoded straight from the state flop.
//   - Both change in the same cycle as the state register.
//
//   Latency
//   - Counted from the first edge that samples locked=1, with lock steady.
//   - ready rises after edge 3+LOCK_STABLE_CYCLES+HOLD_CYCLES.
//   - Loss of lock in RUN: reset_out rises 3 edges after the first edge that samples locked=0.
//   - A lock glitch shorter than one cycle may be missed; that is acceptable.
//
//   reset
//   - Applies at the next edge from any state, including mid-HOLD or mid-STABLE.
//   - Clears sync1, sync2, cnt and lock_loss_count; state <= WAIT_LOCK.
//   - Values after reset: reset_out=1, ready=0, lock_loss_count=0.
//   - reset has priority over all transitions and over the counter increment.
//
//   Boundary conditions
//   - Lock drop in STABLE or HOLD: return to WAIT_LOCK; lock_loss_count does NOT change.
//   - lock_loss_count holds at all-ones once reached.
//   - Sequence restarts from cnt=0 on every re-entry to STABLE; no partial credit.
//   - Lock drop on the same edge cnt hits terminal in STABLE or HOLD: the drop wins (WAIT_LOCK).
//
// TESTING (bench parameters: LOCK_STABLE_CYCLES=4, HOLD_CYCLES=8, LOSS_COUNT_WIDTH=2)
//   1 Apply reset, locked=0 for 20 cycles -> reset_out=1, ready=0, count=0 throughout.
//   2 Raise locked and hold it -> ready rises exactly after edge 15;
//     reset_out falls on the same edge.
//   3 In RUN, drop locked -> reset_out=1 after 3rd edge, count=1;
//     re-raise -> ready again 15 edges later.
//   4 Drop locked for 1 cycle mid-HOLD (after edge 10) -> back to WAIT_LOCK,
//     full 4+8 restart, count unchanged.
//   5 Five RUN->loss cycles -> count reads 1,2,3,3,3 (saturates).
//   6 Assert reset for 1 cycle mid-STABLE and again in RUN with count=2
//     -> next edge: WAIT_LOCK, reset_out=1, count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Qualifies the PLL lock flag on the pixel clock and releases a clean synchronous
// reset to the VGA core only after lock has been stable and a hold time has elapsed.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 256,
  parameter int LOSS_COUNT_WIDTH   = 8
) (
  input  logic                        clock_in,
  input  logic                        reset,
  input  logic                        locked,
  output logic                        reset_out,
  output logic                        ready,
  output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    WAIT_LOCK = 4'b0001,
    STABLE    = 4'b0010,
    HOLD      = 4'b0100,
    RUN       = 4'b1000
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LOSS_COUNT_WIDTH-1:0] loss_q, loss_d;
  logic                        sync1_q, sync1_d;
  logic                        sync2_q, sync2_d;
  logic                        locked_s;

  function automatic logic [LOSS_COUNT_WIDTH-1:0] sat_inc(input logic [LOSS_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign locked_s = sync2_q;

  always_comb begin
    sync1_d = locked;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // Only a loss after full qualification counts as a lock-loss event.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          loss_d  = sat_inc(loss_q);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
    end
  end

  assign ready           = state_q[3];
  assign reset_out       = ~state_q[3];
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short qualification times (4 stable, 8 hold).
module tb_pll_reset_sequencer;

  logic       clock_in = 1'b0;
  logic       reset;
  logic       locked;
  logic       reset_out;
  logic       ready;
  logic [1:0] lock_loss_count;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(4),
    .HOLD_CYCLES       (8),
    .LOSS_COUNT_WIDTH  (2)
  ) dut (
    .clock_in       (clock_in),
    .reset          (reset),
    .locked         (locked),
    .reset_out      (reset_out),
    .ready          (ready),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Expects ready low for n-1 edges and high (reset_out low) after edge n.
  task automatic run_to_ready(input string tag, input int n);
    for (int i = 1; i < n; i++) begin
      tick();
      chk({tag, "_early"}, ready, 0);
    end
    tick();
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_rstout"}, reset_out, 0);
  endtask

  // Drops lock in RUN; reset_out must stay low for two edges and rise on the third.
  task automatic lose_lock(input string tag, input int exp_count);
    locked = 1'b0;
    tick();
    tick();
    chk({tag, "_still_run"}, reset_out, 0);
    tick();
    chk({tag, "_rstout"}, reset_out, 1);
    chk({tag, "_count"}, lock_loss_count, exp_count);
  endtask

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_rstout", reset_out, 1);
    chk("rst_ready", ready, 0);
    chk("rst_count", lock_loss_count, 0);

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nolock_state", {reset_out, ready, lock_loss_count}, 4'b1000);
    end

    locked = 1'b1;
    run_to_ready("lock1", 15);

    lose_lock("loss1", 1);
    locked = 1'b1;
    run_to_ready("relock1", 15);

    lose_lock("loss2", 2);
    tick();
    tick();
    locked = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("glitch_pre", ready, 0);
    end
    locked = 1'b0;
    tick();
    locked = 1'b1;
    for (int e = 12; e < 26; e++) begin
      tick();
      chk("glitch_restart", ready, 0);
    end
    tick();
    chk("glitch_ready", ready, 1);
    chk("glitch_count", lock_loss_count, 2);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_count", lock_loss_count, 0);
    chk("rst2_rstout", reset_out, 1);
    for (int k = 0; k < 5; k++) begin
      locked = 1'b1;
      run_to_ready("sat_lock", 15);
      lose_lock("sat", (k < 3) ? k + 1 : 3);
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    locked = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_stable_rstout", reset_out, 1);
    chk("rst_stable_ready", ready, 0);
    chk("rst_stable_count", lock_loss_count, 0);
    run_to_ready("after_rst_stable", 15);

    lose_lock("pre_rst_a", 1);
    locked = 1'b1;
    run_to_ready("pre_rst_a_lock", 15);
    lose_lock("pre_rst_b", 2);
    locked = 1'b1;
    run_to_ready("pre_rst_b_lock", 15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run_rstout", reset_out, 1);
    chk("rst_run_ready", ready, 0);
    chk("rst_run_count", lock_loss_count, 0);
    run_to_ready("after_rst_run", 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
